bp_cce_hybrid_pending_write_arbiter: RTL and testbench

//  Sequences and shares the single write port of the hybrid CCE pending-bit counter array among three requesters: clear, down (memory response) and up (new LCE request).

---
 rtl/bp_cce_hybrid_pending_write_arbiter_pkg.sv | 15 +
 rtl/bp_cce_hybrid_pending_write_arbiter_counter.sv | 33 +++
 rtl/bp_cce_hybrid_pending_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bp_cce_hybrid_pending_write_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_hybrid_pending_write_arbiter_pkg.sv
// Shared types and helpers for the pending-bit write arbiter.
package bp_me_pkg;

  // Arbiter phase: initial clear sweep, then live arbitration.
  typedef enum logic {
    e_pb_arb_init,
    e_pb_arb_ready
  } bp_cce_pb_arb_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cce_hybrid_pending_write_arbiter_counter.sv
// Up counter with synchronous clear; clear together with up loads one.
module bp_cce_hybrid_pending_write_arbiter_counter
  #(parameter int width_p = 3)
  (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
  );

  logic [width_p-1:0] count_d, count_q;

  // Next count: clear has priority, optionally seeding the count with one.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = width_p'(up_i);
    else if (up_i)
      count_d = count_q + width_p'(1);
  end

  // Count register, zeroed by asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cce_hybrid_pending_write_arbiter.sv
// Shares the pending-bit counter write port among clear, down and up
// requesters after sweeping every way-group counter to zero following reset.
module bp_cce_hybrid_pending_write_arbiter
  import bp_me_pkg::*;
  #(parameter int num_way_groups_p = 8,
    parameter int paddr_width_p    = 40,
    parameter int addr_offset_p    = 6,
    parameter int cce_way_groups_p = 64,
    parameter int starve_limit_p   = 4)
  (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     clr_v_i,
    input  logic [paddr_width_p-1:0] clr_addr_i,
    input  logic                     clr_bypass_i,
    input  logic                     clr_up_i,
    output logic                     clr_ready_o,

    input  logic                     dn_v_i,
    input  logic [paddr_width_p-1:0] dn_addr_i,
    input  logic                     dn_bypass_i,
    output logic                     dn_ready_o,

    input  logic                     up_v_i,
    input  logic [paddr_width_p-1:0] up_addr_i,
    input  logic                     up_bypass_i,
    output logic                     up_ready_o,

    output logic                     w_v_o,
    output logic [paddr_width_p-1:0] w_addr_o,
    output logic                     w_bypass_o,
    output logic                     w_up_o,
    output logic                     w_down_o,
    output logic                     w_clear_o,
    output logic                     init_done_o
  );

  localparam int lg_cce_way_groups_lp = safe_clog2(cce_way_groups_p);
  localparam int init_cnt_width_lp    = safe_clog2(num_way_groups_p);
  localparam int starve_width_lp      = safe_clog2(starve_limit_p + 1);

  localparam logic [init_cnt_width_lp-1:0] init_last_lp = init_cnt_width_lp'(num_way_groups_p - 1);
  localparam logic [starve_width_lp-1:0]   starve_max_lp = starve_width_lp'(starve_limit_p);

  bp_cce_pb_arb_state_e state_d, state_q;
  logic [starve_width_lp-1:0]   starve_cnt_d, starve_cnt_q;
  logic [init_cnt_width_lp-1:0] init_cnt;
  logic init_up, init_clear;

  logic                     clr_ready, dn_ready, up_ready;
  logic                     w_v, w_bypass, w_up, w_down, w_clear, init_done;
  logic [paddr_width_p-1:0] w_addr;

  logic init_last, same_wg, forced_up;

  // Sweep index; wraps to zero when the sweep finishes.
  bp_cce_hybrid_pending_write_arbiter_counter
    #(.width_p(init_cnt_width_lp))
    init_counter
     (.clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (init_clear),
      .up_i    (init_up),
      .count_o (init_cnt));

  // Cancellation and starvation qualifiers derived from the live requests.
  always_comb begin
    init_last = (init_cnt == init_last_lp);
    same_wg   = up_v_i && dn_v_i && (up_bypass_i == dn_bypass_i)
                && (up_addr_i[addr_offset_p+:lg_cce_way_groups_lp]
                    == dn_addr_i[addr_offset_p+:lg_cce_way_groups_lp]);
    forced_up = up_v_i && (starve_cnt_q == starve_max_lp);
  end

  // Next state and grant: sweep writes in INIT, single-winner arbitration in READY.
  always_comb begin
    state_d    = state_q;
    init_up    = 1'b0;
    init_clear = 1'b0;
    clr_ready  = 1'b0;
    dn_ready   = 1'b0;
    up_ready   = 1'b0;
    w_v        = 1'b0;
    w_addr     = '0;
    w_bypass   = 1'b0;
    w_up       = 1'b0;
    w_down     = 1'b0;
    w_clear    = 1'b0;
    init_done  = 1'b0;
    unique case (state_q)
      e_pb_arb_init: begin
        w_v      = 1'b1;
        w_clear  = 1'b1;
        w_bypass = 1'b1;
        w_addr   = paddr_width_p'(init_cnt);
        if (init_last) begin
          init_clear = 1'b1;
          state_d    = e_pb_arb_ready;
        end else begin
          init_up = 1'b1;
        end
      end
      e_pb_arb_ready: begin
        init_done = 1'b1;
        // A forced up that collides with a same-group down still cancels;
        // otherwise it pre-empts clear and down.
        if (forced_up && same_wg) begin
          up_ready = 1'b1;
          dn_ready = 1'b1;
        end else if (forced_up) begin
          up_ready = 1'b1;
          w_v      = 1'b1;
          w_addr   = up_addr_i;
          w_bypass = up_bypass_i;
          w_up     = 1'b1;
        end else if (clr_v_i) begin
          clr_ready = 1'b1;
          w_v       = 1'b1;
          w_addr    = clr_addr_i;
          w_bypass  = clr_bypass_i;
          w_clear   = 1'b1;
          w_up      = clr_up_i;
        end else if (same_wg) begin
          up_ready = 1'b1;
          dn_ready = 1'b1;
        end else if (dn_v_i) begin
          dn_ready = 1'b1;
          w_v      = 1'b1;
          w_addr   = dn_addr_i;
          w_bypass = dn_bypass_i;
          w_down   = 1'b1;
        end else if (up_v_i) begin
          up_ready = 1'b1;
          w_v      = 1'b1;
          w_addr   = up_addr_i;
          w_bypass = up_bypass_i;
          w_up     = 1'b1;
        end
      end
      default: state_d = e_pb_arb_init;
    endcase
  end

  // Starvation count: consecutive cycles up waits, saturating at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (up_v_i && !up_ready)
      starve_cnt_d = (starve_cnt_q == starve_max_lp) ? starve_max_lp
                                                     : starve_cnt_q + starve_width_lp'(1);
  end

  // State and starvation registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= e_pb_arb_init;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // All outputs are held low while reset is asserted.
  always_comb begin
    clr_ready_o = !reset_i && clr_ready;
    dn_ready_o  = !reset_i && dn_ready;
    up_ready_o  = !reset_i && up_ready;
    w_v_o       = !reset_i && w_v;
    w_addr_o    = reset_i ? '0 : w_addr;
    w_bypass_o  = !reset_i && w_bypass;
    w_up_o      = !reset_i && w_up;
    w_down_o    = !reset_i && w_down;
    w_clear_o   = !reset_i && w_clear;
    init_done_o = !reset_i && init_done;
  end

  a_clr_ready_v: assert property (@(posedge clk_i) disable iff (reset_i) clr_ready_o |-> clr_v_i);
  a_dn_ready_v:  assert property (@(posedge clk_i) disable iff (reset_i) dn_ready_o |-> dn_v_i);
  a_up_ready_v:  assert property (@(posedge clk_i) disable iff (reset_i) up_ready_o |-> up_v_i);
  a_up_dn_excl:  assert property (@(posedge clk_i) disable iff (reset_i) !(w_up_o && w_down_o));
  a_w_v_state:   assert property (@(posedge clk_i) disable iff (reset_i)
                                  w_v_o |-> (state_q == e_pb_arb_init || state_q == e_pb_arb_ready));
  a_init_range:  assert property (@(posedge clk_i) disable iff (reset_i)
                                  int'(init_cnt) < num_way_groups_p);

endmodule

// File: tb/tb_bp_cce_hybrid_pending_write_arbiter.sv
// Self-checking bench for the pending-bit write arbiter: directed scenarios
// plus randomized traffic compared against a rule-level reference model.
module tb_bp_cce_hybrid_pending_write_arbiter;

  localparam int NWG = 8;
  localparam int PAW = 40;
  localparam int OFF = 6;
  localparam int CWG = 64;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset_i;
  logic clr_v_i, clr_bypass_i, clr_up_i, clr_ready_o;
  logic dn_v_i, dn_bypass_i, dn_ready_o;
  logic up_v_i, up_bypass_i, up_ready_o;
  logic [PAW-1:0] clr_addr_i, dn_addr_i, up_addr_i, w_addr_o;
  logic w_v_o, w_bypass_o, w_up_o, w_down_o, w_clear_o, init_done_o;

  int n_cmp = 0;
  int n_fail = 0;
  int m_starve = 0;

  typedef struct packed {
    logic cr, dr, ur, wv;
    logic [PAW-1:0] wa;
    logic wb, wu, wd, wc, id;
  } out_t;

  always #5 clk = ~clk;

  bp_cce_hybrid_pending_write_arbiter
    #(.num_way_groups_p(NWG), .paddr_width_p(PAW), .addr_offset_p(OFF),
      .cce_way_groups_p(CWG), .starve_limit_p(LIM))
    dut
     (.clk_i(clk), .reset_i(reset_i),
      .clr_v_i(clr_v_i), .clr_addr_i(clr_addr_i), .clr_bypass_i(clr_bypass_i),
      .clr_up_i(clr_up_i), .clr_ready_o(clr_ready_o),
      .dn_v_i(dn_v_i), .dn_addr_i(dn_addr_i), .dn_bypass_i(dn_bypass_i), .dn_ready_o(dn_ready_o),
      .up_v_i(up_v_i), .up_addr_i(up_addr_i), .up_bypass_i(up_bypass_i), .up_ready_o(up_ready_o),
      .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_bypass_o(w_bypass_o), .w_up_o(w_up_o),
      .w_down_o(w_down_o), .w_clear_o(w_clear_o), .init_done_o(init_done_o));

  function automatic out_t obs();
    return {clr_ready_o, dn_ready_o, up_ready_o, w_v_o, w_addr_o,
            w_bypass_o, w_up_o, w_down_o, w_clear_o, init_done_o};
  endfunction

  // Expected output during sweep step i.
  function automatic out_t init_vec(input int i);
    out_t e = '0;
    e.wv = 1'b1; e.wc = 1'b1; e.wb = 1'b1; e.wa = PAW'(i);
    return e;
  endfunction

  function automatic int wg_of(input logic [PAW-1:0] a);
    return int'((a >> OFF) % CWG);
  endfunction

  // Rule-level reference: decide the winner from the current requests.
  // winner: 0 none, 1 clear, 2 down, 3 up, 4 cancel.
  function automatic void model(input int s, output out_t e, output bit up_acc);
    int winner;
    bit same;
    same = up_v_i && dn_v_i && (up_bypass_i == dn_bypass_i) && (wg_of(up_addr_i) == wg_of(dn_addr_i));
    if (up_v_i && s == LIM) winner = same ? 4 : 3;
    else if (clr_v_i)       winner = 1;
    else if (same)          winner = 4;
    else if (dn_v_i)        winner = 2;
    else if (up_v_i)        winner = 3;
    else                    winner = 0;
    e = '0;
    e.id = 1'b1;
    case (winner)
      1: begin e.cr = 1; e.wv = 1; e.wa = clr_addr_i; e.wb = clr_bypass_i; e.wc = 1; e.wu = clr_up_i; end
      2: begin e.dr = 1; e.wv = 1; e.wa = dn_addr_i; e.wb = dn_bypass_i; e.wd = 1; end
      3: begin e.ur = 1; e.wv = 1; e.wa = up_addr_i; e.wb = up_bypass_i; e.wu = 1; end
      4: begin e.ur = 1; e.dr = 1; end
      default: ;
    endcase
    up_acc = (winner == 3) || (winner == 4);
  endfunction

  function automatic int next_starve(input int s, input bit up_acc);
    if (up_v_i && !up_acc) return (s >= LIM) ? LIM : s + 1;
    return 0;
  endfunction

  function automatic logic [PAW-1:0] rand_addr();
    return (PAW'($urandom_range(0, 3)) << 12) | (PAW'($urandom_range(0, 3)) << OFF)
           | PAW'($urandom_range(0, 63));
  endfunction

  task automatic idle();
    clr_v_i = 0; clr_addr_i = '0; clr_bypass_i = 0; clr_up_i = 0;
    dn_v_i = 0; dn_addr_i = '0; dn_bypass_i = 0;
    up_v_i = 0; up_addr_i = '0; up_bypass_i = 0;
  endtask

  task automatic test_reset();
    out_t o, e;
    reset_i = 1'b1;
    idle();
    @(negedge clk);
    o = obs(); n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", o); end
    clr_v_i = 1; clr_addr_i = PAW'(5); dn_v_i = 1; dn_addr_i = PAW'(9);
    @(negedge clk);
    o = obs(); n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL reset_outputs_with_valids: got %h expected 0", o); end
    @(posedge clk); #1;
    reset_i = 1'b0;
    for (int i = 0; i < NWG; i++) begin
      @(negedge clk);
      o = obs(); e = init_vec(i); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL sweep step %0d: got %h expected %h", i, o, e); end
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    o = obs(); e = '0; e.id = 1'b1; n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL init_done_cycle9: got %h expected %h", o, e); end
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  task automatic test_reset_mid_sweep();
    out_t o, e;
    idle();
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_i = 1'b1;
    #1;
    o = obs(); n_cmp++;
    if (o !== '0) begin n_fail++; $display("FAIL midsweep_reset_outputs: got %h expected 0", o); end
    @(posedge clk); #1;
    reset_i = 1'b0;
    for (int i = 0; i < NWG; i++) begin
      @(negedge clk);
      o = obs(); e = init_vec(i); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL resweep step %0d: got %h expected %h", i, o, e); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    o = obs(); e = '0; e.id = 1'b1; n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL resweep_done: got %h expected %h", o, e); end
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  task automatic test_clr_up();
    out_t o, e;
    idle();
    clr_v_i = 1; clr_up_i = 1; clr_bypass_i = 1; clr_addr_i = PAW'(3);
    @(negedge clk);
    o = obs();
    e = '0; e.cr = 1; e.wv = 1; e.wa = PAW'(3); e.wb = 1; e.wu = 1; e.wc = 1; e.id = 1;
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL clr_up_write: got %h expected %h", o, e); end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  task automatic test_priority();
    out_t o, e;
    bit ua;
    logic [2:0] want [3] = '{3'b100, 3'b010, 3'b001};
    int writes = 0;
    idle();
    clr_v_i = 1; clr_addr_i = PAW'(1) << OFF;
    dn_v_i  = 1; dn_addr_i  = PAW'(2) << OFF;
    up_v_i  = 1; up_addr_i  = PAW'(3) << OFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      o = obs();
      model(m_starve, e, ua);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL priority model cyc%0d: got %h expected %h", k, o, e); end
      if (k < 3) begin
        n_cmp++;
        if ({o.cr, o.dr, o.ur} !== want[k])
          begin n_fail++; $display("FAIL priority order cyc%0d: got %b expected %b", k, {o.cr, o.dr, o.ur}, want[k]); end
      end
      writes += int'(o.wv);
      m_starve = next_starve(m_starve, ua);
      @(posedge clk); #1;
      if (e.cr) clr_v_i = 0;
      if (e.dr) dn_v_i = 0;
      if (e.ur) up_v_i = 0;
    end
    n_cmp++;
    if (writes != 3) begin n_fail++; $display("FAIL priority write_count: got %0d expected 3", writes); end
    idle();
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  task automatic test_starve();
    out_t o, e;
    bit ua;
    idle();
    dn_v_i = 1; dn_addr_i = PAW'(5) << OFF;
    up_v_i = 1; up_addr_i = PAW'(6) << OFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      o = obs();
      model(m_starve, e, ua);
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL starve model cyc%0d: got %h expected %h", k, o, e); end
      n_cmp++;
      if ({o.dr, o.ur} !== ((k == 5) ? 2'b01 : 2'b10))
        begin n_fail++; $display("FAIL starve grant cyc%0d: got dr/ur %b expected %b", k, {o.dr, o.ur}, (k == 5) ? 2'b01 : 2'b10); end
      m_starve = next_starve(m_starve, ua);
      @(posedge clk); #1;
      dn_addr_i = dn_addr_i + PAW'(1);
    end
    idle();
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  task automatic test_cancel();
    out_t o, e;
    bit ua;
    idle();
    up_v_i = 1; up_addr_i = PAW'('h1040);
    dn_v_i = 1; dn_addr_i = PAW'('h1040);
    @(negedge clk);
    o = obs();
    model(m_starve, e, ua);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL cancel model: got %h expected %h", o, e); end
    n_cmp++;
    if ({o.dr, o.ur, o.wv} !== 3'b110) begin n_fail++; $display("FAIL cancel flags: got %b expected 110", {o.dr, o.ur, o.wv}); end
    m_starve = next_starve(m_starve, ua);
    @(posedge clk); #1;
    clr_v_i = 1; clr_addr_i = PAW'('h2000);
    @(negedge clk);
    o = obs();
    model(m_starve, e, ua);
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL cancel_with_clr model: got %h expected %h", o, e); end
    n_cmp++;
    if ({o.cr, o.dr, o.ur, o.wv, o.wc} !== 5'b10011)
      begin n_fail++; $display("FAIL cancel_with_clr flags: got %b expected 10011", {o.cr, o.dr, o.ur, o.wv, o.wc}); end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  task automatic test_random();
    out_t o, e;
    bit ua;
    int errs = 0;
    idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      o = obs();
      model(m_starve, e, ua);
      n_cmp++;
      if (o !== e) begin
        n_fail++; errs++;
        if (errs <= 10) $display("FAIL random cyc%0d: got %h expected %h", k, o, e);
      end
      m_starve = next_starve(m_starve, ua);
      @(posedge clk); #1;
      if (!clr_v_i || e.cr) begin
        clr_v_i = ($urandom_range(0, 3) == 0); clr_addr_i = rand_addr();
        clr_bypass_i = $urandom_range(0, 1) == 1; clr_up_i = $urandom_range(0, 1) == 1;
      end
      if (!dn_v_i || e.dr) begin
        dn_v_i = ($urandom_range(0, 1) == 1); dn_addr_i = rand_addr();
        dn_bypass_i = ($urandom_range(0, 3) == 0);
      end
      if (!up_v_i || e.ur) begin
        up_v_i = ($urandom_range(0, 2) != 0); up_addr_i = rand_addr();
        up_bypass_i = ($urandom_range(0, 3) == 0);
      end
    end
    idle();
    @(posedge clk); #1;
    m_starve = 0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    test_reset();
    test_reset_mid_sweep();
    test_clr_up();
    test_priority();
    test_starve();
    test_cancel();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
